// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART image loader.
// LOADER_CHECKSUM_EN adds the CSUM state encoding.
package loader_pkg;

    localparam int         ADDR_W    = 21;
    localparam int         LEN_W     = ADDR_W - 1;
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_LEN2 = 3'd3,
        ST_DATA = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_DONE = 3'd6
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// SRAM programming bus driven by the loader, plus its status flags.
interface uart_loader_if;
    import loader_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_wr_en;
    logic [7:0]        mem_wd;
    logic              uart_sel;
    logic              load_done;
    logic              load_error;

    modport master (output mem_address, mem_wr_en, mem_wd, uart_sel, load_done, load_error);
    modport slave  (input  mem_address, mem_wr_en, mem_wd, uart_sel, load_done, load_error);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer; emits one-cycle valid and
// framing-error pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_DIV = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_rx_d;
    rx_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_ferr, w_ferr_nxt;
    logic          w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_rx_d  <= w_rx;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rx_d && !w_rx) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = HALF;
                end
            end
            RX_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rx) begin
                    w_state_nxt = RX_IDLE;   // glitch, not a real start bit
                end else begin
                    w_state_nxt = RX_DATA;
                    w_cnt_nxt   = FULL;
                    w_bit_nxt   = '0;
                end
            end
            RX_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_cnt_nxt   = FULL;
                    if (r_bit == 3'd7) w_state_nxt = RX_STOP;
                    else               w_bit_nxt   = r_bit + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = RX_IDLE;
                    w_valid_nxt = w_rx;
                    w_ferr_nxt  = !w_rx;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_loader.sv
// Serial SRAM image loader: sync byte, 24-bit LE length, then data bytes.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
//
// state | meaning
// IDLE  | after reset, waiting for sync byte 0x55
// LEN0  | length bits [7:0]
// LEN1  | length bits [15:8]
// LEN2  | length bits [23:16], only [19:16] kept
// DATA  | writing payload bytes to SRAM
// CSUM  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | image complete, waiting for a new sync byte
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_DIV   = 217,
    parameter int WR_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          uart_rx,
    uart_loader_if.master mem
);
    localparam int             WCW     = $clog2(WR_CYCLES);
    localparam logic [WCW-1:0] WR_LAST = WCW'(WR_CYCLES - 1);

    logic [7:0]     w_rx_byte;
    logic           w_rx_valid, w_rx_ferr;

    load_state_t    r_state, w_state_nxt;
    logic [LEN_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [7:0]     r_wd, w_wd_nxt;
    logic           r_wr_en, w_wr_en_nxt;
    logic [WCW-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic           r_gap, w_gap_nxt;
    logic           r_sel, w_sel_nxt;
    logic           r_done, w_done_nxt;
    logic           r_err, w_err_nxt;
    logic           w_fin;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     r_sum, w_sum_nxt;
`endif

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .i_rx        (uart_rx),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_wd     <= '0;
            r_wr_en  <= 1'b0;
            r_wr_cnt <= '0;
            r_gap    <= 1'b0;
            r_sel    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_len    <= w_len_nxt;
            r_wd     <= w_wd_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_gap    <= w_gap_nxt;
            r_sel    <= w_sel_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_sum    <= w_sum_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_len_nxt    = r_len;
        w_wd_nxt     = r_wd;
        w_wr_en_nxt  = r_wr_en;
        w_wr_cnt_nxt = r_wr_cnt;
        w_gap_nxt    = 1'b0;
        w_sel_nxt    = r_sel;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_fin        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nxt    = r_sum;
`endif
        if (w_rx_ferr) w_err_nxt = 1'b1;

        // Write window, then one low gap cycle in which the address advances.
        if (r_wr_en) begin
            if (r_wr_cnt == '0) begin
                w_wr_en_nxt = 1'b0;
                w_gap_nxt   = 1'b1;
            end else begin
                w_wr_cnt_nxt = r_wr_cnt - 1'b1;
            end
        end
        if (r_gap) begin
            w_addr_nxt = r_addr + 1'b1;
            w_fin      = ((r_addr + 1'b1) == r_len);
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_rx_valid && w_rx_byte == SYNC_BYTE) begin
                    w_state_nxt = ST_LEN0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_addr_nxt  = '0;
                    w_sel_nxt   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (w_rx_valid) begin
                    w_len_nxt   = {r_len[19:8], w_rx_byte};
                    w_state_nxt = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_rx_valid) begin
                    w_len_nxt   = {r_len[19:16], w_rx_byte, r_len[7:0]};
                    w_state_nxt = ST_LEN2;
                end
            end
            ST_LEN2: begin
                if (w_rx_valid) begin
                    w_len_nxt = {w_rx_byte[3:0], r_len[15:0]};
                    if (w_len_nxt == '0) w_fin       = 1'b1;
                    else                 w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_rx_valid) begin
                    if (r_wr_en || r_gap) begin
                        w_err_nxt = 1'b1;   // overrun: drop byte, finish current write
                    end else begin
                        w_wd_nxt     = w_rx_byte;
                        w_wr_en_nxt  = 1'b1;
                        w_wr_cnt_nxt = WR_LAST;
`ifdef LOADER_CHECKSUM_EN
                        w_sum_nxt    = r_sum + w_rx_byte;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (w_rx_valid) begin
                    if (w_rx_byte != r_sum) w_err_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_sel_nxt   = 1'b0;
                end
            end
`endif
            default: ;
        endcase

        if (w_fin) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = ST_CSUM;
`else
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_sel_nxt   = 1'b0;
`endif
        end
    end

    assign mem.mem_address = {1'b0, r_addr};
    assign mem.mem_wr_en   = r_wr_en;
    assign mem.mem_wd      = r_wd;
    assign mem.uart_sel    = r_sel;
    assign mem.load_done   = r_done;
    assign mem.load_error  = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed vector table, reset-mid-write
// sequence and randomized images checked against a byte-stream model.
module tb_uart_loader;
    import loader_pkg::*;

    localparam int CLK_DIV   = 16;
    localparam int WR_CYCLES = 4;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic rx_line = 1'b1;

    uart_loader_if u_if ();

    uart_loader #(.CLK_DIV(CLK_DIV), .WR_CYCLES(WR_CYCLES)) dut (
        .clock   (clock),
        .reset   (reset),
        .uart_rx (rx_line),
        .mem     (u_if)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  data;
        logic [7:0]  width;
        logic        stable;
    } wr_rec_t;

    typedef struct packed {
        logic [3:0]      n;
        logic [0:7][7:0] b;
        logic [0:7]      bad;
        logic [2:0]      nw;
        logic [0:3][7:0] wd;
        logic            err;
    } vec_t;

    // Write-window monitor: records every completed mem_wr_en window.
    wr_rec_t     wq[$];
    logic        in_win   = 1'b0;
    logic        stable_w = 1'b1;
    logic [20:0] cap_a    = '0;
    logic [7:0]  cap_d    = '0;
    int          width_w  = 0;
    int          sel_bad  = 0;

    always @(negedge clock) begin
        if (reset) begin
            in_win = 1'b0;
        end else if (u_if.mem_wr_en) begin
            if (!u_if.uart_sel) sel_bad++;
            if (!in_win) begin
                in_win   = 1'b1;
                cap_a    = u_if.mem_address;
                cap_d    = u_if.mem_wd;
                width_w  = 1;
                stable_w = 1'b1;
            end else begin
                width_w++;
                if (u_if.mem_address != cap_a || u_if.mem_wd != cap_d) stable_w = 1'b0;
            end
        end else if (in_win) begin
            wr_rec_t r;
            r.addr   = cap_a;
            r.data   = cap_d;
            r.width  = 8'(width_w);
            r.stable = stable_w;
            wq.push_back(r);
            in_win = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx_line = 1'b0;
        repeat (CLK_DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CLK_DIV) @(negedge clock);
        end
        rx_line = stop;
        repeat (CLK_DIV) @(negedge clock);
        rx_line = 1'b1;
        repeat (CLK_DIV) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Compare writes recorded since index base against the expected byte list.
    task automatic check_image(input string tag, input int base, input int sel_base,
                               input logic [7:0] expd[$], input logic exp_err);
        int nrec;
        nrec = wq.size() - base;
        chk($sformatf("%s nwrites", tag), 32'(nrec), 32'(expd.size()));
        for (int i = 0; i < nrec && i < expd.size(); i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), 32'(wq[base+i].addr), 32'(i));
            chk($sformatf("%s wr%0d data", tag, i), 32'(wq[base+i].data), 32'(expd[i]));
            chk($sformatf("%s wr%0d width", tag, i), 32'(wq[base+i].width), 32'(WR_CYCLES));
            chk($sformatf("%s wr%0d stable", tag, i), 32'(wq[base+i].stable), 32'd1);
        end
        chk($sformatf("%s load_done", tag), 32'(u_if.load_done), 32'd1);
        chk($sformatf("%s load_error", tag), 32'(u_if.load_error), 32'(exp_err));
        chk($sformatf("%s uart_sel", tag), 32'(u_if.uart_sel), 32'd0);
        chk($sformatf("%s sel_during_wr", tag), 32'(sel_bad - sel_base), 32'd0);
    endtask

    vec_t       vecs[$];
    logic [7:0] expd[$];
    logic [7:0] rb;
    logic [7:0] rsum;
    logic       rerr;
    logic       seen;
    int         base;
    int         sbase;
    int         rlen;

    initial begin
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{4'd8, {8'h55,8'h03,8'h00,8'h00,8'hAA,8'hBB,8'hCC,8'h31}, 8'b0000_0000,
                         3'd3, {8'hAA,8'hBB,8'hCC,8'h00}, 1'b0});
        vecs.push_back('{4'd5, {8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'b0000_0000,
                         3'd0, {8'h00,8'h00,8'h00,8'h00}, 1'b0});
        vecs.push_back('{4'd8, {8'h12,8'h34,8'h55,8'h01,8'h00,8'h00,8'h5A,8'h5A}, 8'b0000_0000,
                         3'd1, {8'h5A,8'h00,8'h00,8'h00}, 1'b0});
        vecs.push_back('{4'd8, {8'h55,8'h02,8'h00,8'h00,8'h11,8'h22,8'h33,8'h55}, 8'b0000_1000,
                         3'd2, {8'h22,8'h33,8'h00,8'h00}, 1'b1});
        vecs.push_back('{4'd6, {8'h55,8'h01,8'h00,8'hF0,8'h77,8'h77,8'h00,8'h00}, 8'b0000_0000,
                         3'd1, {8'h77,8'h00,8'h00,8'h00}, 1'b0});
        vecs.push_back('{4'd6, {8'h55,8'h01,8'h00,8'h00,8'h10,8'h11,8'h00,8'h00}, 8'b0000_0000,
                         3'd1, {8'h10,8'h00,8'h00,8'h00}, 1'b1});
`else
        vecs.push_back('{4'd7, {8'h55,8'h03,8'h00,8'h00,8'hAA,8'hBB,8'hCC,8'h00}, 8'b0000_0000,
                         3'd3, {8'hAA,8'hBB,8'hCC,8'h00}, 1'b0});
        vecs.push_back('{4'd4, {8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'b0000_0000,
                         3'd0, {8'h00,8'h00,8'h00,8'h00}, 1'b0});
        vecs.push_back('{4'd7, {8'h12,8'h34,8'h55,8'h01,8'h00,8'h00,8'h5A,8'h00}, 8'b0000_0000,
                         3'd1, {8'h5A,8'h00,8'h00,8'h00}, 1'b0});
        vecs.push_back('{4'd7, {8'h55,8'h02,8'h00,8'h00,8'h11,8'h22,8'h33,8'h00}, 8'b0000_1000,
                         3'd2, {8'h22,8'h33,8'h00,8'h00}, 1'b1});
        vecs.push_back('{4'd5, {8'h55,8'h01,8'h00,8'hF0,8'h77,8'h00,8'h00,8'h00}, 8'b0000_0000,
                         3'd1, {8'h77,8'h00,8'h00,8'h00}, 1'b0});
`endif

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst mem_address", 32'(u_if.mem_address), 32'd0);
        chk("rst mem_wr_en",   32'(u_if.mem_wr_en),   32'd0);
        chk("rst mem_wd",      32'(u_if.mem_wd),      32'd0);
        chk("rst uart_sel",    32'(u_if.uart_sel),    32'd0);
        chk("rst load_done",   32'(u_if.load_done),   32'd0);
        chk("rst load_error",  32'(u_if.load_error),  32'd0);
        reset = 1'b0;

        // Directed vector table
        foreach (vecs[v]) begin
            do_reset();
            base  = wq.size();
            sbase = sel_bad;
            for (int i = 0; i < int'(vecs[v].n); i++)
                send_byte(vecs[v].b[i], !vecs[v].bad[i]);
            repeat (30) @(negedge clock);
            expd.delete();
            for (int i = 0; i < int'(vecs[v].nw); i++) expd.push_back(vecs[v].wd[i]);
            check_image($sformatf("vec%0d", v), base, sbase, expd, vecs[v].err);
        end

        // Reset asserted in the second cycle of a write window
        do_reset();
        send_byte(8'h55, 1'b1);
        chk("sync uart_sel", 32'(u_if.uart_sel), 32'd1);
        chk("sync load_done", 32'(u_if.load_done), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        seen = 1'b0;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clock);
                    seen = u_if.mem_wr_en;
                end
                chk("midwr window seen", 32'(seen), 32'd1);
                if (seen) begin
                    @(posedge clock);
                    #1 reset = 1'b1;
                    #1;
                    chk("midwr mem_wr_en",   32'(u_if.mem_wr_en),   32'd0);
                    chk("midwr mem_address", 32'(u_if.mem_address), 32'd0);
                    chk("midwr mem_wd",      32'(u_if.mem_wd),      32'd0);
                    chk("midwr uart_sel",    32'(u_if.uart_sel),    32'd0);
                    chk("midwr load_done",   32'(u_if.load_done),   32'd0);
                    chk("midwr load_error",  32'(u_if.load_error),  32'd0);
                end
            end
        join
        repeat (2) @(negedge clock);
        reset = 1'b0;
        base = wq.size();
        send_byte(8'h77, 1'b1);
        repeat (20) @(negedge clock);
        chk("abandon no write", 32'(wq.size() - base), 32'd0);
        chk("abandon load_done", 32'(u_if.load_done), 32'd0);

        // Randomized images, back to back without reset
        for (int it = 0; it < 8; it++) begin
            base  = wq.size();
            sbase = sel_bad;
            expd.delete();
            rsum = 8'h00;
            rerr = 1'b0;
            rlen = $urandom_range(1, 6);
            repeat ($urandom_range(0, 2)) begin
                rb = 8'($urandom);
                if (rb == SYNC_BYTE) rb = 8'h56;
                send_byte(rb, 1'b1);
            end
            send_byte(SYNC_BYTE, 1'b1);
            send_byte(8'(rlen), 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte({4'($urandom_range(0, 15)), 4'h0}, 1'b1);
            for (int i = 0; i < rlen; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    send_byte(8'($urandom), 1'b0);
                    rerr = 1'b1;
                end
                rb = 8'($urandom);
                send_byte(rb, 1'b1);
                expd.push_back(rb);
                rsum = rsum + rb;
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(rsum, 1'b1);
`endif
            repeat (30) @(negedge clock);
            check_image($sformatf("rnd%0d", it), base, sbase, expd, rerr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
